// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM encoding and SPI mode constants for spi_slave.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XFER = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - input sampler and edge detector for one SPI pin.
// Define SPI_SLAVE_SYNC_EN to insert a 2-flop synchronizer ahead of the sampler.
module spi_slave_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic stage_in;

`ifdef SPI_SLAVE_SYNC_EN
    logic [1:0] meta_q;
    logic [1:0] meta_d;

    always_comb meta_d = {meta_q[0], din};

    always_ff @(posedge clk) begin
        if (rst) meta_q <= {2{RESET_VAL}};
        else     meta_q <= meta_d;
    end

    assign stage_in = meta_q[1];
`else
    assign stage_in = din;
`endif

    logic samp_q, samp_d;
    logic prev_q, prev_d;

    always_comb begin
        samp_d = stage_in;
        prev_d = samp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            samp_q <= samp_d;
            prev_q <= prev_d;
        end
    end

    assign dout = samp_q;
    assign rise = samp_q & ~prev_q;
    assign fall = ~samp_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave with one-word TX holding buffer, any CPOL/CPHA mode.
// Define SPI_SLAVE_SYNC_EN when sclk/csn/mosi are asynchronous to clk.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_send,
    input  logic                  send_valid,
    output logic                  send_ready,
    input  logic                  sclk,
    input  logic                  csn,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] data_recv,
    output logic                  recv_valid
);

    localparam spi_mode_t MODE = '{cpol: (CPOL != 0), cpha: (CPHA != 0)};
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    // Cycles after reset before sampled csn reflects the pin rather than its reset value.
`ifdef SPI_SLAVE_SYNC_EN
    localparam logic [2:0] SETTLE = 3'd4;
`else
    localparam logic [2:0] SETTLE = 3'd2;
`endif

    logic sclk_s, sclk_rise, sclk_fall;
    logic csn_s, csn_rise, csn_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync #(.RESET_VAL(MODE.cpol)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_slave_sync #(.RESET_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rst(rst), .din(csn), .dout(csn_s), .rise(csn_rise), .fall(csn_fall)
    );
    spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s),
        .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] data_recv_q, data_recv_d;
    logic                  recv_valid_q, recv_valid_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            settle_q, settle_d;
    logic                  lead_edge, trail_edge, sample_edge, shift_edge;

    always_comb begin
        lead_edge   = MODE.cpol ? sclk_fall : sclk_rise;
        trail_edge  = MODE.cpol ? sclk_rise : sclk_fall;
        sample_edge = MODE.cpha ? trail_edge : lead_edge;
        shift_edge  = MODE.cpha ? lead_edge : trail_edge;
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        rx_d         = rx_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        data_recv_d  = data_recv_q;
        recv_valid_d = 1'b0;
        cnt_d        = cnt_q;
        settle_d     = (settle_q < SETTLE) ? settle_q + 3'd1 : settle_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                rx_d  = '0;
                if (csn_fall && settle_q == SETTLE) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d     = hold_full_q ? hold_q : '0;
                hold_full_d = 1'b0;
                state_d     = ST_XFER;
            end
            ST_XFER: begin
                if (!csn_s && sample_edge) begin
                    rx_d = (rx_q << 1) | DATA_WIDTH'(mosi_s);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d        = '0;
                        data_recv_d  = rx_d;
                        recv_valid_d = 1'b1;
                        if (MODE.cpha) state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // cnt_q == 0 marks a word boundary: CPHA=1 skips its first shift,
                // CPHA=0 reloads instead of shifting after the last bit.
                if (!csn_s && shift_edge) begin
                    if (MODE.cpha) begin
                        if (cnt_q != '0) shift_d = shift_q << 1;
                    end else if (cnt_q == '0) begin
                        state_d = ST_LOAD;
                    end else begin
                        shift_d = shift_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && csn_rise) state_d = ST_IDLE;

        if (send_valid && !hold_full_q) begin
            hold_d      = data_send;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            rx_q         <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            data_recv_q  <= '0;
            recv_valid_q <= 1'b0;
            cnt_q        <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            rx_q         <= rx_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            data_recv_q  <= data_recv_d;
            recv_valid_q <= recv_valid_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
        end
    end

    assign send_ready = ~hold_full_q;
    assign miso       = (state_q != ST_IDLE) ? shift_q[DATA_WIDTH-1] : 1'b0;
    assign data_recv  = data_recv_q;
    assign recv_valid = recv_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench driving a mode-0 and a mode-3 spi_slave in lockstep.
module tb_spi_slave;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_m = 1'b0;
    logic       sclk3;
    logic       csn = 1'b1;
    logic       mosi = 1'b0;
    logic       send_valid = 1'b0;
    logic [7:0] data_send = 8'h00;

    logic       send_ready0, miso0, recv_valid0;
    logic       send_ready3, miso3, recv_valid3;
    logic [7:0] data_recv0, data_recv3;

    int n_checks = 0;
    int n_errors = 0;
    int rv0 = 0;
    int rv3 = 0;

    logic [7:0] mo_w [5];
    logic [7:0] tx_w [5];
    bit         tx_en [5];
    logic [7:0] last_rx = 8'h00;

    assign sclk3 = ~sclk_m;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (recv_valid0) rv0 <= rv0 + 1;
        if (recv_valid3) rv3 <= rv3 + 1;
    end

    spi_slave #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_send(data_send), .send_valid(send_valid),
        .send_ready(send_ready0), .sclk(sclk_m), .csn(csn), .mosi(mosi),
        .miso(miso0), .data_recv(data_recv0), .recv_valid(recv_valid0)
    );

    spi_slave #(.DATA_WIDTH(8), .CPOL(1), .CPHA(1)) u_dut3 (
        .clk(clk), .rst(rst), .data_send(data_send), .send_valid(send_valid),
        .send_ready(send_ready3), .sclk(sclk3), .csn(csn), .mosi(mosi),
        .miso(miso3), .data_recv(data_recv3), .recv_valid(recv_valid3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready0"}, 32'(send_ready0), 1);
        check({tag, "_ready3"}, 32'(send_ready3), 1);
        check({tag, "_rv0"}, 32'(recv_valid0), 0);
        check({tag, "_rv3"}, 32'(recv_valid3), 0);
        check({tag, "_rx0"}, 32'(data_recv0), 0);
        check({tag, "_rx3"}, 32'(data_recv3), 0);
        check({tag, "_miso0"}, 32'(miso0), 0);
        check({tag, "_miso3"}, 32'(miso3), 0);
    endtask

    task automatic push(input logic [7:0] w);
        check("ready_before_push0", 32'(send_ready0), 1);
        check("ready_before_push3", 32'(send_ready3), 1);
        send_valid = 1'b1;
        data_send  = w;
        tick(1);
        send_valid = 1'b0;
        data_send  = 8'($urandom);
        check("ready_after_push0", 32'(send_ready0), 0);
        check("ready_after_push3", 32'(send_ready3), 0);
    endtask

    // Master side: mosi settles H/2 before the first edge of each bit; each DUT's miso
    // is captured just before that DUT's sampling edge.
    task automatic run_word(input logic [7:0] mo, input int nbits, input int push_at,
                            input logic [7:0] push_w,
                            output logic [7:0] mi0, output logic [7:0] mi3);
        mi0 = 8'h00;
        mi3 = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            mosi = mo[7-b];
            if (b == push_at) push(push_w);
            tick(H/2);
            mi0 = {mi0[6:0], miso0};
            sclk_m = 1'b1;
            tick(H);
            mi3 = {mi3[6:0], miso3};
            sclk_m = 1'b0;
            tick(H/2);
        end
    endtask

    // Word i transmits tx_w[i] if tx_en[i], else zeros; word 0 is handed over before
    // csn falls, later words are handed over during the preceding word.
    task automatic xfer(input int n);
        logic [7:0] mi0, mi3, exp_tx;
        int b0, b3, pa;
        if (tx_en[0]) push(tx_w[0]);
        csn = 1'b0;
        tick(H);
        for (int i = 0; i < n; i++) begin
            exp_tx = tx_en[i] ? tx_w[i] : 8'h00;
            b0 = rv0;
            b3 = rv3;
            pa = -1;
            if (i + 1 < n && tx_en[i+1]) pa = int'($urandom_range(1, 6));
            run_word(mo_w[i], 8, pa, tx_w[i+1], mi0, mi3);
            tick(2);
            check("miso_word_m0", 32'(mi0), 32'(exp_tx));
            check("miso_word_m3", 32'(mi3), 32'(exp_tx));
            check("data_recv_m0", 32'(data_recv0), 32'(mo_w[i]));
            check("data_recv_m3", 32'(data_recv3), 32'(mo_w[i]));
            check("pulses_m0", 32'(rv0 - b0), 1);
            check("pulses_m3", 32'(rv3 - b3), 1);
        end
        csn = 1'b1;
        tick(H);
        check("ready_idle0", 32'(send_ready0), 1);
        check("ready_idle3", 32'(send_ready3), 1);
        last_rx = mo_w[n-1];
    endtask

    initial begin
        logic [7:0] mi0, mi3;
        int b0, b3, n;

        tick(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(4);

        mo_w[0] = 8'h3C; tx_w[0] = 8'hA5; tx_en[0] = 1'b1;
        xfer(1);

        mo_w[0] = 8'hC3; tx_w[0] = 8'h5A; tx_en[0] = 1'b1;
        xfer(1);

        mo_w[0] = 8'hFF; tx_en[0] = 1'b0;
        xfer(1);

        mo_w[0] = 8'($urandom); mo_w[1] = 8'($urandom);
        tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_en[0] = 1'b1; tx_en[1] = 1'b1;
        xfer(2);

        csn = 1'b0;
        tick(H);
        b0 = rv0;
        b3 = rv3;
        run_word(8'($urandom), 5, -1, 8'h00, mi0, mi3);
        csn = 1'b1;
        tick(H);
        check("partial_pulses_m0", 32'(rv0 - b0), 0);
        check("partial_pulses_m3", 32'(rv3 - b3), 0);
        check("partial_rx_m0", 32'(data_recv0), 32'(last_rx));
        check("partial_rx_m3", 32'(data_recv3), 32'(last_rx));
        check("partial_ready0", 32'(send_ready0), 1);

        mo_w[0] = 8'h81; tx_en[0] = 1'b0; tx_en[1] = 1'b0;
        xfer(1);

        push(8'hE7);
        csn = 1'b0;
        tick(H);
        run_word(8'hFF, 4, -1, 8'h00, mi0, mi3);
        rst = 1'b1;
        tick(2);
        check_reset_outputs("midrst");
        rst = 1'b0;
        b0 = rv0;
        b3 = rv3;
        run_word(8'hFF, 8, -1, 8'h00, mi0, mi3);
        tick(2);
        check("held_low_miso_m0", 32'(mi0), 0);
        check("held_low_miso_m3", 32'(mi3), 0);
        check("held_low_pulses_m0", 32'(rv0 - b0), 0);
        check("held_low_pulses_m3", 32'(rv3 - b3), 0);
        check("held_low_rx_m0", 32'(data_recv0), 0);
        csn = 1'b1;
        tick(H);
        mo_w[0] = 8'($urandom); tx_w[0] = 8'($urandom); tx_en[0] = 1'b1;
        xfer(1);

        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < 5; i++) begin
                mo_w[i]  = 8'($urandom);
                tx_w[i]  = 8'($urandom);
                tx_en[i] = 1'($urandom);
            end
            xfer(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set bits per SPI word.
REQ-002 Parameter CPOL, default 0, SHALL set SCLK idle level: 0 idle low, 1 idle high.
REQ-003 Parameter CPHA, default 0, SHALL select sampling: 0 samples on the leading edge, 1 samples on the trailing edge.
REQ-004 clk  input  1  SHALL be the single system clock.
REQ-005 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 data_send  input  DATA_WIDTH  SHALL be the next word to transmit on miso.
REQ-007 send_valid  input  1  SHALL qualify data_send.
REQ-008 send_ready  output  1  SHALL be high while the TX holding buffer is empty.
REQ-009 sclk  input  1  SHALL be the SPI clock from the master, asynchronous to clk.
REQ-010 csn  input  1  SHALL be the active-low chip select, asynchronous to clk.
REQ-011 mosi  input  1  SHALL be master-out serial data, MSB first.
REQ-012 miso  output  1  SHALL be slave-out serial data, MSB first.
REQ-013 data_recv  output  DATA_WIDTH  SHALL hold the last complete received word.
REQ-014 recv_valid  output  1  SHALL pulse for one clk cycle per completed word.

Function
REQ-015 sclk, csn and mosi SHALL be sampled on clk; sclk edges and csn falling/rising edges SHALL be detected by comparing the current and previous sampled values.
REQ-016 The FSM SHALL have the states IDLE, LOAD and XFER: IDLE->LOAD on a csn falling edge; LOAD->XFER after exactly one cycle; LOAD or XFER->IDLE on a csn rising edge.
REQ-017 The handshake SHALL complete when send_valid and send_ready are both high; data_send SHALL then be latched into the holding buffer and send_ready SHALL drop on the next cycle.
REQ-018 In LOAD, the shift register SHALL load the holding buffer if it is full, or all-zeros if it is empty (underrun), and the holding buffer SHALL then be marked empty.
REQ-019 miso SHALL equal the shift register MSB in LOAD and XFER, and 0 in IDLE.
REQ-020 The leading edge SHALL be rising when CPOL=0 and falling when CPOL=1.
REQ-021 With CPHA=0, mosi SHALL be sampled on the leading edge and the shift register SHALL shift left on the trailing edge.
REQ-022 With CPHA=1, the shift register SHALL shift left on every leading edge except the first of each word, and mosi SHALL be sampled on the trailing edge.
REQ-023 A bit counter SHALL count samples; on the DATA_WIDTH-th sample, data_recv SHALL update to the full word in the following cycle, recv_valid SHALL pulse in that same cycle, and the counter SHALL wrap to 0.
REQ-024 If csn is still low after a word completes, the FSM SHALL pass through LOAD again, reloading per REQ-018, before the next word.
REQ-025 A handshake in the same cycle as a LOAD SHALL fill the buffer for the following word and SHALL NOT affect the word being loaded.
REQ-026 A csn rising edge before DATA_WIDTH samples SHALL discard the partial word: no recv_valid, data_recv unchanged, and the holding buffer unchanged.
REQ-027 Correct operation SHALL be required only for SCLK half-periods of at least 4 clk cycles and a csn-fall-to-first-edge gap of at least 4 clk cycles.

Reset
REQ-028 While rst is high, the FSM SHALL go to IDLE and data_recv, recv_valid, miso, the shift register and the bit counter SHALL be 0; send_ready SHALL be 1.
REQ-029 Sampled csn SHALL reset to 1 and sampled sclk SHALL reset to CPOL, so that csn held low through reset release SHALL NOT start a transfer.
REQ-030 rst asserted mid-transfer SHALL abort the transfer; the next transfer SHALL begin only on a new csn falling edge.

Configuration
REQ-031 With SPI_SLAVE_SYNC_EN defined, sclk, csn and mosi SHALL each pass through a 2-flop synchronizer before edge detection, adding 2 cycles of latency.
REQ-032 Without SPI_SLAVE_SYNC_EN, the inputs SHALL be registered once only, and the block SHALL require them to be synchronous to clk.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state encoding (IDLE/LOAD/XFER) and the SPI mode constants (CPOL/CPHA pairs).
REQ-034 Synchronization and edge detection SHALL be a sub-module spi_slave_sync, instantiated once per input.

Verification
REQ-035 Mode 0, 0xA5 loaded, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; data_recv=0x3C; exactly one recv_valid pulse.
REQ-036 Mode 3 (CPOL=1, CPHA=1), 0x5A loaded, master sends 0xC3 -> miso=0x5A and data_recv=0xC3.
REQ-037 No word loaded, master sends 0xFF -> miso all 0; data_recv=0xFF; recv_valid pulses.
REQ-038 csn held low for 16 bits, 0x11 loaded, then 0x22 loaded mid-word -> miso 0x11 then 0x22; two recv_valid pulses.
REQ-039 csn rises after 5 bits, then a full transfer of 0x81 -> no pulse after the partial word; data_recv=0x81 after the full transfer.
REQ-040 rst pulsed at bit 4, csn held low -> all outputs at reset values; no transfer until csn rises and falls again.
